// File: rtl/mem_mul_seq_ctrl.sv
// mem_mul_seq_ctrl: owns a DEPTH x DATA_W single-port RAM and a registered HALF x HALF multiplier.
//   It walks LEN words from BASE (address wraps at DEPTH) and streams hi*lo for each word.
//   Mode 0 writes each product back in place; mode 1 only streams it.
// Latency: one word every 4 cycles (RD, LAT, MUL, WB). With start at edge E0, word k is
//   presented in cycle 4k+4 and done pulses in cycle 4*len+1.
// Backpressure: none. out_valid is a 1-cycle pulse the consumer must take. start is ignored
//   while busy. abort returns the FSM to IDLE.
// Ports:
//   i_clk, i_rst                  clock; asynchronous active-high reset
//   i_start, i_abort, i_mode      run control (i_mode: 0 = write back, 1 = stream only)
//   i_base, i_len                 first address and word count (0..DEPTH, larger values clamp)
//   i_host_we/addr/wdata          host RAM access while idle
//   o_host_rdata                  registered host read data; holds its value while busy
//   o_busy, o_done                run status (o_done pulses only when a run ends normally)
//   o_out_valid/data/addr         product stream
module mem_mul_seq_ctrl #(
  parameter int DATA_W = 56,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W:0]   i_len,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic [DATA_W-1:0] o_host_rdata,
  output logic              o_busy,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic              o_done
);

  localparam int HALF  = DATA_W / 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_L  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_MUL,
    S_WB,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_ram_q;
  logic [DATA_W-1:0] r_host_rdata;

  logic              r_mode;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [HALF-1:0]   r_hi;
  logic [HALF-1:0]   r_lo;
  logic [DATA_W-1:0] r_prod;

  logic              w_accept;
  logic              w_last;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [ADDR_W:0]   w_len_clamped;

  assign w_len_clamped = (i_len > DEPTH_L) ? DEPTH_L : i_len;
  assign w_last        = (r_cnt == (r_len - LEN_ONE));

  // The RAM port belongs to the host only while idle. During a run it follows the walk address.
  assign w_ram_addr  = (r_state == S_IDLE) ? i_host_addr : r_addr;
  assign w_ram_wdata = (r_state == S_IDLE) ? i_host_wdata : r_prod;

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_ram_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ram_we = i_host_we;
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = (i_len == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:  w_next = S_LAT;
      S_LAT: w_next = S_MUL;
      S_MUL: w_next = S_WB;
      S_WB: begin
        // An abort landing on WB still shows the product but must not commit it to RAM.
        w_ram_we = !r_mode && !i_abort;
        w_next   = w_last ? S_DONE : S_RD;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // In IDLE, abort is ignored, so start wins when both are high.
    if (r_state != S_IDLE && i_abort) begin
      w_next = S_IDLE;
    end
    // Reset stops RAM writes at once, including a host write that is pending.
    if (i_rst) begin
      w_ram_we = 1'b0;
    end
  end

  // RAM array and its read register. Neither is reset; reads return the old data (read-first).
  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      r_mem[w_ram_addr] <= w_ram_wdata;
    end
    r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_prod       <= '0;
      r_host_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode <= i_mode;
        r_addr <= i_base;
        r_len  <= w_len_clamped;
        r_cnt  <= '0;
      end
      if (r_state == S_LAT) begin
        r_hi <= r_ram_q[DATA_W-1:HALF];
        r_lo <= r_ram_q[HALF-1:0];
      end
      if (r_state == S_MUL) begin
        r_prod <= DATA_W'(r_hi) * DATA_W'(r_lo);
      end
      // The address register is only N bits wide, so the increment wraps modulo DEPTH.
      if (r_state == S_WB && !w_last) begin
        r_cnt  <= r_cnt + LEN_ONE;
        r_addr <= r_addr + ADDR_ONE;
      end
      // The host read register freezes during a run, so the host keeps its last read value.
      if (r_state == S_IDLE) begin
        r_host_rdata <= r_mem[i_host_addr];
      end
    end
  end

  // Status outputs are decoded from the state register only.
  assign o_busy       = (r_state != S_IDLE);
  assign o_out_valid  = (r_state == S_WB);
  assign o_done       = (r_state == S_DONE);
  assign o_out_data   = r_prod;
  assign o_out_addr   = r_addr;
  assign o_host_rdata = r_host_rdata;

endmodule

// File: tb/tb_mem_mul_seq_ctrl.sv
// Self-checking bench for mem_mul_seq_ctrl. A word-level reference RAM plus plain
// hi*lo arithmetic predicts every streamed product, the pulse timing and RAM contents.
module tb_mem_mul_seq_ctrl;

  localparam int DW    = 56;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort_i, mode;
  logic [AW-1:0] base;
  logic [AW:0]   len;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          busy, out_valid, done;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  mem_mul_seq_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort_i), .i_mode(mode),
    .i_base(base), .i_len(len), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_rdata(host_rdata), .o_busy(busy),
    .o_out_valid(out_valid), .o_out_data(out_data), .o_out_addr(out_addr), .o_done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] prod_of(input logic [DW-1:0] w);
    longint unsigned hi, lo;
    hi = longint'(w[55:28]);
    lo = longint'(w[27:0]);
    return DW'(hi * lo);
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom, $urandom});
  endfunction

  task automatic host_write(input int a, input logic [DW-1:0] d);
    host_we = 1'b1; host_addr = AW'(a); host_wdata = d;
    tick();
    host_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic host_check(input int a);
    host_addr = AW'(a);
    tick();
    chk("host_rdata", 64'(host_rdata), 64'(ref_mem[a]));
  endtask

  // Run one job. abort_k >= 0 aborts during the WB cycle of word abort_k.
  // A stray start pulse is injected mid-run to confirm that it is ignored.
  task automatic run(input int b, input int l, input bit m, input int abort_k, input bit abort_with_start);
    int eff, last, k, a;
    logic [DW-1:0] p;
    eff = (l > DEPTH) ? DEPTH : l;
    start = 1'b1; base = AW'(b); len = (AW+1)'(l); mode = m; abort_i = abort_with_start;
    tick();
    start = 1'b0; abort_i = 1'b0;
    last = (abort_k >= 0) ? 4 * abort_k + 4 : 4 * eff + 1;
    for (int c = 1; c <= last; c++) begin
      chk("busy_run", 64'(busy), 64'(1));
      if (c == 2) begin
        start = 1'b1; base = AW'($urandom); len = 1;
      end else begin
        start = 1'b0;
      end
      if (c % 4 == 0 && c / 4 <= eff) begin
        k = c / 4 - 1;
        a = (b + k) % DEPTH;
        p = prod_of(ref_mem[a]);
        chk("out_valid", 64'(out_valid), 64'(1));
        chk("out_data", 64'(out_data), 64'(p));
        chk("out_addr", 64'(out_addr), 64'(a));
        if (!m && abort_k != k) ref_mem[a] = p;
      end else begin
        chk("out_valid_idle", 64'(out_valid), 64'(0));
      end
      chk("done", 64'(done), 64'((c == 4 * eff + 1 && abort_k < 0) ? 1 : 0));
      if (c == last && abort_k >= 0) abort_i = 1'b1;
      tick();
    end
    abort_i = 1'b0; start = 1'b0;
    chk("busy_after", 64'(busy), 64'(0));
    chk("valid_after", 64'(out_valid), 64'(0));
    chk("done_after", 64'(done), 64'(0));
  endtask

  initial begin
    int b;
    rst = 1'b1; start = 0; abort_i = 0; mode = 0; base = '0; len = '0;
    host_we = 0; host_addr = '0; host_wdata = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_addr", 64'(out_addr), 64'(0));
    chk("rst_hrdata", 64'(host_rdata), 64'(0));
    rst = 1'b0;
    tick();

    // Single word, written back in place.
    host_write(0, {28'd3, 28'd5});
    run(0, 1, 1'b0, -1, 1'b0);
    host_check(0);
    chk("t1_value", 64'(host_rdata), 64'd15);

    // Wrap across the top of the RAM, stream only.
    host_write(510, {28'd7, 28'd9});
    host_write(511, {28'hFFFFFFF, 28'hFFFFFFF});
    host_write(0, {28'd0, 28'd123});
    run(510, 3, 1'b1, -1, 1'b0);
    host_check(510); host_check(511); host_check(0);

    // len = 0, with abort raised alongside start: start wins and done pulses in cycle 1.
    run(37, 0, 1'b0, -1, 1'b1);

    // Full sweep over random data with write-back, then read the whole RAM back.
    for (int i = 0; i < DEPTH; i++) host_write(i, (i % 97 == 0) ? {DW{1'b1}} : rnd_word());
    run(int'($urandom_range(0, DEPTH - 1)), DEPTH, 1'b0, -1, 1'b0);
    for (int i = 0; i < DEPTH; i++) host_check(i);

    // Lengths above DEPTH clamp to DEPTH.
    run(int'($urandom_range(0, DEPTH - 1)), 700, 1'b1, -1, 1'b0);

    // Abort during WB of word 1: word 0 is written, word 1 is not, and a later start runs normally.
    b = int'($urandom_range(0, DEPTH - 1));
    run(b, 4, 1'b0, 1, 1'b0);
    for (int i = 0; i < 4; i++) host_check((b + i) % DEPTH);
    run(int'($urandom_range(0, DEPTH - 1)), 3, 1'b0, -1, 1'b0);

    // Short random runs.
    for (int r = 0; r < 6; r++) begin
      b = int'($urandom_range(0, DEPTH - 1));
      run(b, int'($urandom_range(1, 6)), 1'($urandom), -1, 1'b0);
      host_check(b);
    end

    // Reset in the middle of MUL, with a host write attempted while busy.
    b = int'($urandom_range(0, DEPTH - 1));
    start = 1'b1; base = AW'(b); len = 4; mode = 1'b0;
    tick();
    start = 1'b0;
    host_we = 1'b1; host_addr = AW'((b + 2) % DEPTH); host_wdata = rnd_word();
    tick();
    host_we = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_data", 64'(out_data), 64'(0));
    chk("mid_rst_addr", 64'(out_addr), 64'(0));
    chk("mid_rst_hrdata", 64'(host_rdata), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) host_check((b + i) % DEPTH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
